// File: rtl/fc_detect_decision_if.sv
// Purpose: bundles FC logits/completion in and per-frame verdict/alarm out for fc_detect_decision.
// Latency: none (wires only); the decision stage answers 2 cycles after fc_done is sampled high.
// Backpressure: none; producer paces fc_done edges at least 2 cycles apart. Optional: DETECT_STATS_EN.
interface fc_detect_decision_if #(
    parameter int datawidth    = 16,
    parameter int output_nodes = 2
);
    logic [datawidth*output_nodes-1:0] fc_data;
    logic                              fc_done;
    logic                              frame_valid;
    logic                              frame_human;
    logic                              frame_nan;
    logic                              alarm;
    logic [1:0]                        state_dbg;
`ifdef DETECT_STATS_EN
    logic [15:0]                       frames_total;
    logic [15:0]                       frames_human;

    modport master (
        output fc_data, fc_done,
        input  frame_valid, frame_human, frame_nan, alarm, state_dbg,
        input  frames_total, frames_human
    );
    modport slave (
        input  fc_data, fc_done,
        output frame_valid, frame_human, frame_nan, alarm, state_dbg,
        output frames_total, frames_human
    );
`else
    modport master (
        output fc_data, fc_done,
        input  frame_valid, frame_human, frame_nan, alarm, state_dbg
    );
    modport slave (
        input  fc_data, fc_done,
        output frame_valid, frame_human, frame_nan, alarm, state_dbg
    );
`endif
endinterface

// File: rtl/fc_detect_decision.sv
// Purpose: latch 2 fp16 FC logits, decide human/no-human per frame, debounce into alarm. Optional: DETECT_STATS_EN.
// Latency: fc_done sampled high at edge N -> frame_valid/verdict/state/alarm update together at edge N+2.
// Backpressure: none; fully registered, one frame per rising edge of fc_done (min spacing 2 cycles).
module fc_detect_decision #(
    parameter int datawidth      = 16,
    parameter int output_nodes   = 2,
    parameter int CONFIRM_FRAMES = 3,
    parameter int RELEASE_FRAMES = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    fc_detect_decision_if.slave  io
);
    typedef enum logic [1:0] {
        CLEAR   = 2'd0,
        PENDING = 2'd1,
        ALARM   = 2'd2,
        HOLD    = 2'd3
    } state_t;

    localparam logic [3:0] CONF_N = 4'(CONFIRM_FRAMES);
    localparam logic [3:0] REL_N  = 4'(RELEASE_FRAMES);

    // Total order over fp16 bit patterns: flip negatives, lift positives above them.
    function automatic logic [datawidth-1:0] order_key(input logic [datawidth-1:0] x);
        return x[datawidth-1] ? ~x : (x | {1'b1, {(datawidth-1){1'b0}}});
    endfunction

    function automatic logic is_nan(input logic [datawidth-1:0] x);
        return (x[14:10] == 5'h1F) && (x[9:0] != 10'd0);
    endfunction

    logic                 fc_done_q;
    logic                 start;
    logic [datawidth-1:0] l0, l1;
    logic                 s1_valid;
    logic                 s2_valid, s2_human, s2_nan;
    logic                 human_c, nan_c, both_zero;
    state_t               state;
    logic [3:0]           cnt;

    assign start = io.fc_done & ~fc_done_q;

    // Reset to 1 so a level held high across reset release is not mistaken for a new frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) fc_done_q <= 1'b1;
        else       fc_done_q <= io.fc_done;
    end

    // Stage 1: capture logits on the rising edge of fc_done; later fc_data changes are ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            l0       <= '0;
            l1       <= '0;
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= start;
            if (start) begin
                l0 <= io.fc_data[datawidth-1:0];
                l1 <= io.fc_data[output_nodes*datawidth-1 -: datawidth];
            end
        end
    end

    // +0 and -0 are equal; any NaN forces not-human; infinities fall out of the key order.
    always_comb begin
        nan_c     = is_nan(l0) | is_nan(l1);
        both_zero = (l0[datawidth-2:0] == '0) && (l1[datawidth-2:0] == '0);
        human_c   = ~nan_c & ~both_zero & (order_key(l1) > order_key(l0));
    end

    // Stage 2a: register the per-frame verdict.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_valid <= 1'b0;
            s2_human <= 1'b0;
            s2_nan   <= 1'b0;
        end else begin
            s2_valid <= s1_valid;
            s2_human <= human_c;
            s2_nan   <= nan_c;
        end
    end

    // Stage 2b: hysteresis FSM; verdict, state and alarm outputs all register on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= CLEAR;
            cnt            <= 4'd0;
            io.frame_valid <= 1'b0;
            io.frame_human <= 1'b0;
            io.frame_nan   <= 1'b0;
            io.alarm       <= 1'b0;
        end else begin
            io.frame_valid <= s2_valid;
            if (s2_valid) begin
                io.frame_human <= s2_human;
                io.frame_nan   <= s2_nan;
                case (state)
                    CLEAR: begin
                        if (s2_human) begin
                            if (CONF_N == 4'd1) begin
                                state    <= ALARM;
                                io.alarm <= 1'b1;
                            end else begin
                                state <= PENDING;
                                cnt   <= 4'd1;
                            end
                        end
                    end
                    PENDING: begin
                        if (s2_human) begin
                            if (cnt + 4'd1 == CONF_N) begin
                                state    <= ALARM;
                                cnt      <= 4'd0;
                                io.alarm <= 1'b1;
                            end else begin
                                cnt <= cnt + 4'd1;
                            end
                        end else begin
                            state <= CLEAR;
                            cnt   <= 4'd0;
                        end
                    end
                    ALARM: begin
                        if (!s2_human) begin
                            if (REL_N == 4'd1) begin
                                state    <= CLEAR;
                                io.alarm <= 1'b0;
                            end else begin
                                state <= HOLD;
                                cnt   <= 4'd1;
                            end
                        end
                    end
                    HOLD: begin
                        if (!s2_human) begin
                            if (cnt + 4'd1 == REL_N) begin
                                state    <= CLEAR;
                                cnt      <= 4'd0;
                                io.alarm <= 1'b0;
                            end else begin
                                cnt <= cnt + 4'd1;
                            end
                        end else begin
                            state <= ALARM;
                            cnt   <= 4'd0;
                        end
                    end
                    default: begin
                        state <= CLEAR;
                        cnt   <= 4'd0;
                    end
                endcase
            end
        end
    end

    assign io.state_dbg = state;

`ifdef DETECT_STATS_EN
    // Saturating frame counters, bumped on the same edge that raises frame_valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            io.frames_total <= 16'd0;
            io.frames_human <= 16'd0;
        end else if (s2_valid) begin
            if (io.frames_total != 16'hFFFF)
                io.frames_total <= io.frames_total + 16'd1;
            if (s2_human && io.frames_human != 16'hFFFF)
                io.frames_human <= io.frames_human + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fc_detect_decision.sv
// Purpose: scoreboard bench for fc_detect_decision; expected verdicts/states queued at stimulus time.
// Latency: each queued entry carries the cycle at which frame_valid must appear (fc_done edge + 2).
// Backpressure: none; frames are driven at the minimum 2-cycle spacing.
module tb_fc_detect_decision;
    localparam int CONF = 3;
    localparam int REL  = 5;

    typedef struct {
        logic       human;
        logic       nan;
        logic [1:0] state;
        logic       alarm;
        int         cyc;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   seen = 0;
    exp_t exp_q[$];

    logic m_alarm;
    int   m_run;
    int   m_tot, m_hum;

    fc_detect_decision_if #(.datawidth(16), .output_nodes(2)) dif ();

    fc_detect_decision #(
        .datawidth(16), .output_nodes(2),
        .CONFIRM_FRAMES(CONF), .RELEASE_FRAMES(REL)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .io   (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic nan16(input logic [15:0] x);
        return (x[14:10] == 5'h1F) && (x[9:0] != 10'd0);
    endfunction

    // Sign/magnitude comparison: is a strictly greater than b (non-NaN inputs).
    function automatic logic greater16(input logic [15:0] a, input logic [15:0] b);
        if (a[14:0] == 15'd0 && b[14:0] == 15'd0) return 1'b0;
        if (a[15] != b[15]) return b[15];
        if (!a[15]) return a[14:0] > b[14:0];
        return a[14:0] < b[14:0];
    endfunction

    // Scoreboard monitor: every frame_valid pops one expectation.
    always @(negedge clk) begin
        if (!reset && dif.frame_valid) begin
            exp_t e;
            seen++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_frame_valid at cycle %0d: got frame_valid=1 required none pending", cyc);
            end else begin
                e = exp_q.pop_front();
                checks++;
                if (cyc !== e.cyc) begin
                    errors++;
                    $display("FAIL latency: frame_valid at cycle %0d required cycle %0d", cyc, e.cyc);
                end
                checks++;
                if (dif.frame_human !== e.human) begin
                    errors++;
                    $display("FAIL frame_human: got %b required %b (cycle %0d)", dif.frame_human, e.human, cyc);
                end
                checks++;
                if (dif.frame_nan !== e.nan) begin
                    errors++;
                    $display("FAIL frame_nan: got %b required %b (cycle %0d)", dif.frame_nan, e.nan, cyc);
                end
                checks++;
                if (dif.state_dbg !== e.state) begin
                    errors++;
                    $display("FAIL state_dbg: got %0d required %0d (cycle %0d)", dif.state_dbg, e.state, cyc);
                end
                checks++;
                if (dif.alarm !== e.alarm) begin
                    errors++;
                    $display("FAIL alarm: got %b required %b (cycle %0d)", dif.alarm, e.alarm, cyc);
                end
            end
        end
    end

    task automatic model_clear();
        m_alarm = 1'b0;
        m_run   = 0;
        m_tot   = 0;
        m_hum   = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset       = 1'b1;
        dif.fc_done = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_clear();
    endtask

    // Drive one frame (node1 = n1, node0 = n0) and queue its expected outcome.
    task automatic send(input logic [15:0] n1, input logic [15:0] n0);
        exp_t e;
        logic h, nn;
        @(negedge clk);
        dif.fc_data = {n1, n0};
        dif.fc_done = 1'b1;
        nn = nan16(n0) || nan16(n1);
        h  = !nn && greater16(n1, n0);
        if (!m_alarm) begin
            if (h) begin
                m_run++;
                if (m_run >= CONF) begin m_alarm = 1'b1; m_run = 0; end
            end else m_run = 0;
        end else begin
            if (!h) begin
                m_run++;
                if (m_run >= REL) begin m_alarm = 1'b0; m_run = 0; end
            end else m_run = 0;
        end
        if (m_tot != 65535) m_tot++;
        if (h && m_hum != 65535) m_hum++;
        e.human = h;
        e.nan   = nn;
        e.alarm = m_alarm;
        e.state = m_alarm ? (m_run != 0 ? 2'd3 : 2'd2) : (m_run != 0 ? 2'd1 : 2'd0);
        e.cyc   = cyc + 3;
        exp_q.push_back(e);
        @(negedge clk);
        dif.fc_done = 1'b0;
        dif.fc_data = $urandom;
    endtask

    task automatic test_reset();
        int s0;
        s0 = seen;
        reset       = 1'b1;
        dif.fc_done = 1'b1;
        dif.fc_data = {16'h4000, 16'h3C00};
        repeat (3) @(negedge clk);
        reset = 1'b0;
        model_clear();
        repeat (5) @(negedge clk);
        checks++;
        if (seen !== s0) begin errors++; $display("FAIL reset_no_frame: got %0d frames required 0", seen - s0); end
        checks++;
        if (dif.frame_valid !== 1'b0) begin errors++; $display("FAIL reset_frame_valid: got %b required 0", dif.frame_valid); end
        checks++;
        if (dif.frame_human !== 1'b0) begin errors++; $display("FAIL reset_frame_human: got %b required 0", dif.frame_human); end
        checks++;
        if (dif.frame_nan !== 1'b0) begin errors++; $display("FAIL reset_frame_nan: got %b required 0", dif.frame_nan); end
        checks++;
        if (dif.alarm !== 1'b0) begin errors++; $display("FAIL reset_alarm: got %b required 0", dif.alarm); end
        checks++;
        if (dif.state_dbg !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d required 0", dif.state_dbg); end
        dif.fc_done = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_confirm();
        do_reset();
        repeat (3) send(16'h4000, 16'h3C00);
        repeat (4) @(negedge clk);
        checks++;
        if (dif.alarm !== 1'b1) begin errors++; $display("FAIL confirm_alarm: got %b required 1", dif.alarm); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL confirm_drain: got %0d pending required 0", exp_q.size()); end
    endtask

    task automatic test_pending_break();
        do_reset();
        send(16'h4000, 16'h3C00);
        send(16'h4000, 16'h3C00);
        send(16'h3C00, 16'h4000);
        send(16'h4000, 16'h3C00);
        repeat (4) @(negedge clk);
        checks++;
        if (dif.state_dbg !== 2'd1) begin errors++; $display("FAIL pending_state: got %0d required 1", dif.state_dbg); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL pending_drain: got %0d pending required 0", exp_q.size()); end
    endtask

    task automatic test_hold_release();
        do_reset();
        repeat (3) send(16'h4000, 16'h3C00);
        repeat (4) send(16'h3C00, 16'h4000);
        send(16'h4000, 16'h3C00);
        repeat (5) send(16'h3C00, 16'h4000);
        repeat (4) @(negedge clk);
        checks++;
        if (dif.alarm !== 1'b0) begin errors++; $display("FAIL release_alarm: got %b required 0", dif.alarm); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL release_drain: got %0d pending required 0", exp_q.size()); end
    endtask

    task automatic test_edge_values();
        do_reset();
        send(16'h8000, 16'h0000);
        send(16'hBC00, 16'h3C00);
        send(16'h3C00, 16'hBC00);
        send(16'h7E00, 16'h3C00);
        send(16'h7C00, 16'h7BFF);
        send(16'h3C00, 16'hFE01);
        send(16'hC000, 16'hBC00);
        send(16'h0001, 16'h8001);
        repeat (4) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL edge_drain: got %0d pending required 0", exp_q.size()); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] a, b;
        do_reset();
        for (int i = 0; i < 60; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            if (i % 3 == 0) begin a = 16'h4000; b = {1'b0, 15'($urandom_range(0, 16'h3FFF))}; end
            send(a, b);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_drain: got %0d pending required 0", exp_q.size()); end
    endtask

    task automatic test_reset_midflight();
        int s0;
        for (int d = 1; d <= 2; d++) begin
            repeat (3) send(16'h4000, 16'h3C00);
            repeat (4) @(negedge clk);
            s0 = seen;
            @(negedge clk);
            dif.fc_data = {16'h4000, 16'h3C00};
            dif.fc_done = 1'b1;
            repeat (d) @(negedge clk);
            reset       = 1'b1;
            dif.fc_done = 1'b0;
            @(negedge clk);
            reset = 1'b0;
            model_clear();
            repeat (5) @(negedge clk);
            checks++;
            if (seen !== s0) begin errors++; $display("FAIL midflight_drop_%0d: got %0d frames required 0", d, seen - s0); end
            checks++;
            if (dif.alarm !== 1'b0 || dif.state_dbg !== 2'd0) begin
                errors++;
                $display("FAIL midflight_state_%0d: got alarm=%b state=%0d required 0/0", d, dif.alarm, dif.state_dbg);
            end
        end
    endtask

`ifdef DETECT_STATS_EN
    task automatic test_stats();
        do_reset();
        for (int i = 0; i < 65540; i++) begin
            if (i % 2 == 0) send(16'h4000, 16'h3C00);
            else            send(16'h3C00, 16'h4000);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (dif.frames_total !== 16'hFFFF) begin errors++; $display("FAIL stats_total: got %h required ffff", dif.frames_total); end
        checks++;
        if (dif.frames_human !== 16'(m_hum)) begin errors++; $display("FAIL stats_human: got %h required %h", dif.frames_human, 16'(m_hum)); end
    endtask
`endif

    initial begin
        reset       = 1'b1;
        dif.fc_done = 1'b1;
        dif.fc_data = '0;
        model_clear();
        test_reset();
        test_confirm();
        test_pending_break();
        test_hold_release();
        test_edge_values();
        test_back_to_back();
        test_reset_midflight();
`ifdef DETECT_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
